// File: rtl/des_round_ctrl.sv
// DES round controller: sequences the 16 Feistel rounds of one block around an
// external key schedule / f-function and returns the swapped preoutput {R16,L16}.
module des_round_ctrl #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        wClk,
  input  logic        wReset,
  input  logic        wStart,
  input  logic        wDecrypt,
  input  logic [63:0] wInputData,
  output logic        wReady,
  output logic        wBusy,
  output logic        wDone,
  output logic [63:0] wOutputData,
  output logic [3:0]  wRoundIndex,
  output logic [31:0] wFeistelIn,
  input  logic [31:0] wFeistelOut
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] l_reg;
  logic [31:0] r_reg;
  logic [3:0]  cnt;
  logic        mode;
  logic [63:0] out_reg;
  logic        done_reg;

  always_ff @(posedge wClk) begin
    if (wReset) begin
      state    <= IDLE;
      l_reg    <= '0;
      r_reg    <= '0;
      cnt      <= '0;
      mode     <= 1'b0;
      out_reg  <= '0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (wStart) begin
            l_reg <= wInputData[63:32];
            r_reg <= wInputData[31:0];
            cnt   <= '0;
            mode  <= wDecrypt;
            state <= RUN;
          end
        end
        RUN: begin
          l_reg <= r_reg;
          r_reg <= l_reg ^ wFeistelOut;
          cnt   <= cnt + 4'd1;
          // Last round: the halves are emitted swapped, so no extra undo-swap step.
          if (cnt == LAST_ROUND) begin
            state    <= IDLE;
            out_reg  <= {l_reg ^ wFeistelOut, r_reg};
            done_reg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by state so a stale decrypt mode never leaks an index of 15 into IDLE.
  always_comb begin
    wRoundIndex = 4'd0;
    if (state == RUN) begin
      wRoundIndex = mode ? (LAST_ROUND - cnt) : cnt;
    end
  end

  assign wReady      = (state == IDLE);
  assign wBusy       = (state == RUN);
  assign wDone       = done_reg;
  assign wOutputData = out_reg;
  assign wFeistelIn  = r_reg;

endmodule
